mmio_hub: RTL and testbench

MMIO_HUB -- requirements
Module: mmio_hub

---
 rtl/mmio_hub.sv | 149 ++++++++++++++
 tb/tb_mmio_hub.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_hub.sv
// Memory-mapped I/O hub: address decode, LED/HEX registers, key FIFO,
// free-running s/ms/us timebase and first-error capture register.
module mmio_hub #(
   parameter int CLK_HZ   = 50000000,
   parameter int LED_W    = 16,
   parameter int SW_W     = 16,
   parameter int KFIFO_AW = 3
) (
   input  logic              clock,
   input  logic              clrn,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   input  logic              we,
   input  logic              re,
   output logic [31:0]       rdata,
   input  logic [31:0]       dmem_rdata,
   output logic              dmem_we,
   input  logic [SW_W-1:0]   sw,
   output logic [LED_W-1:0]  led,
   output logic [31:0]       hex,
   input  logic [7:0]        key_code,
   input  logic              key_valid,
   output logic              key_irq
);

   typedef enum logic [11:0] {
      R_DATA  = 12'h000, R_KCODE = 12'h100, R_KSTAT = 12'h101,
      R_LED   = 12'h200, R_HEX   = 12'h201, R_CS    = 12'h300,
      R_CMS   = 12'h301, R_CUS   = 12'h302, R_SW    = 12'h400,
      R_ERR   = 12'h500
   } region_e;

   localparam int DEPTH  = 1 << KFIFO_AW;
   localparam int CNT_W  = KFIFO_AW + 1;
   localparam int PRE_DIV = CLK_HZ / 1000000;
   localparam int PRE_W  = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

   logic [11:0]         region;
   logic                unused_addr_bits;
   logic                mapped, writable, rd_err, wr_err;
   logic                empty, full, pop, push_ok;
   logic                us_tick, ms_tick, s_tick;

   logic [7:0]          mem_q [DEPTH];
   logic [KFIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                ovf_q, ovf_d, irq_q, irq_d;
   logic [LED_W-1:0]    led_q, led_d;
   logic [31:0]         hex_q, hex_d, err_q, err_d;
   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [9:0]          sub_us_q, sub_us_d, sub_ms_q, sub_ms_d;
   logic [31:0]         us_q, us_d, ms_q, ms_d, s_q, s_d;

   assign region           = addr[31:20];
   assign unused_addr_bits = ^addr[19:0];
   assign dmem_we          = we & (region == R_DATA);
   assign led              = led_q;
   assign hex              = hex_q;
   assign key_irq          = irq_q;
   assign empty            = (count_q == '0);
   assign full             = (count_q == CNT_W'(DEPTH));

   always_comb begin
      mapped   = 1'b1;
      writable = 1'b0;
      rdata    = '0;
      case (region)
         R_DATA:  begin rdata = dmem_rdata; writable = 1'b1; end
         R_KCODE: rdata = empty ? '0 : 32'(mem_q[rd_ptr_q]);
         R_KSTAT: begin
            rdata = {ovf_q, 31'b0} | (32'(count_q) << 8) | {31'b0, empty};
            writable = 1'b1;
         end
         R_LED:   begin rdata = 32'(led_q); writable = 1'b1; end
         R_HEX:   begin rdata = hex_q; writable = 1'b1; end
         R_CS:    rdata = s_q;
         R_CMS:   rdata = ms_q;
         R_CUS:   begin rdata = us_q; writable = 1'b1; end
         R_SW:    rdata = 32'(sw);
         R_ERR:   begin rdata = err_q; writable = 1'b1; end
         default: mapped = 1'b0;
      endcase
   end

   always_comb begin
      rd_err = re & ~mapped;
      wr_err = we & ~writable;
      err_d  = err_q;
      if ((rd_err | wr_err) & ~err_q[31])
         err_d = {1'b1, wr_err, 18'b0, region};
      if (we & (region == R_ERR))
         err_d = '0;

      led_d = led_q;
      hex_d = hex_q;
      if (we & (region == R_LED)) led_d = wdata[LED_W-1:0];
      if (we & (region == R_HEX)) hex_d = wdata;
   end

   // A pop frees the slot the same cycle, so a full FIFO still accepts a push.
   always_comb begin
      pop      = re & (region == R_KCODE) & ~empty;
      push_ok  = key_valid & (~full | pop);
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
      irq_d    = (count_d != '0);
      ovf_d    = ovf_q;
      if (key_valid & full & ~pop)     ovf_d = 1'b1;
      if (we & (region == R_KSTAT))    ovf_d = 1'b0;
   end

   always_comb begin
      us_tick  = (pre_q == PRE_W'(PRE_DIV - 1));
      ms_tick  = us_tick & (sub_us_q == 10'd999);
      s_tick   = ms_tick & (sub_ms_q == 10'd999);
      pre_d    = us_tick ? '0 : pre_q + 1'b1;
      sub_us_d = us_tick ? (ms_tick ? '0 : sub_us_q + 10'd1) : sub_us_q;
      sub_ms_d = ms_tick ? (s_tick ? '0 : sub_ms_q + 10'd1) : sub_ms_q;
      us_d     = us_q + 32'(us_tick);
      ms_d     = ms_q + 32'(ms_tick);
      s_d      = s_q + 32'(s_tick);
      if (we & (region == R_CUS)) begin
         pre_d = '0; sub_us_d = '0; sub_ms_d = '0;
         us_d  = '0; ms_d     = '0; s_d      = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_q[wr_ptr_q] <= key_code;
   end

   always_ff @(posedge clock or negedge clrn) begin
      if (!clrn) begin
         wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0;
         ovf_q    <= 1'b0; irq_q <= 1'b0;
         led_q    <= '0; hex_q <= '0; err_q <= '0;
         pre_q    <= '0; sub_us_q <= '0; sub_ms_q <= '0;
         us_q     <= '0; ms_q <= '0; s_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
         ovf_q    <= ovf_d; irq_q <= irq_d;
         led_q    <= led_d; hex_q <= hex_d; err_q <= err_d;
         pre_q    <= pre_d; sub_us_q <= sub_us_d; sub_ms_q <= sub_ms_d;
         us_q     <= us_d; ms_q <= ms_d; s_q <= s_d;
      end
   end

endmodule

// File: tb/tb_mmio_hub.sv
// Randomized self-checking bench for mmio_hub against a queue/arithmetic model.
module tb_mmio_hub;

   localparam logic [31:0] A_DATA  = 32'h0000_0000;
   localparam logic [31:0] A_KCODE = 32'h1000_0000;
   localparam logic [31:0] A_KSTAT = 32'h1010_0000;
   localparam logic [31:0] A_LED   = 32'h2000_0000;
   localparam logic [31:0] A_HEX   = 32'h2010_0000;
   localparam logic [31:0] A_CS    = 32'h3000_0000;
   localparam logic [31:0] A_CMS   = 32'h3010_0000;
   localparam logic [31:0] A_CUS   = 32'h3020_0000;
   localparam logic [31:0] A_SW    = 32'h4000_0000;
   localparam logic [31:0] A_ERR   = 32'h5000_0000;

   logic        clock = 1'b0;
   logic        clrn = 1'b0;
   logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
   logic        we = 1'b0, re = 1'b0, key_valid = 1'b0;
   logic [7:0]  key_code = '0;
   logic [15:0] sw = '0;
   logic [31:0] rdata, hex;
   logic        dmem_we, key_irq;
   logic [15:0] led;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] q[$];
   logic       ovf_m;

   always #5 clock = ~clock;

   mmio_hub #(.CLK_HZ(2000000), .LED_W(16), .SW_W(16), .KFIFO_AW(3)) dut (
      .clock(clock), .clrn(clrn), .addr(addr), .wdata(wdata), .we(we), .re(re),
      .rdata(rdata), .dmem_rdata(dmem_rdata), .dmem_we(dmem_we), .sw(sw),
      .led(led), .hex(hex), .key_code(key_code), .key_valid(key_valid),
      .key_irq(key_irq)
   );

   function automatic logic [31:0] stat_exp();
      logic [31:0] v;
      v = '0;
      v[31] = ovf_m;
      v[11:8] = 4'(q.size());
      v[0] = (q.size() == 0);
      return v;
   endfunction

   function automatic bit is_mapped(logic [11:0] r);
      return r inside {12'h000, 12'h100, 12'h101, 12'h200, 12'h201,
                       12'h300, 12'h301, 12'h302, 12'h400, 12'h500};
   endfunction

   function automatic bit is_writable(logic [11:0] r);
      return r inside {12'h000, 12'h101, 12'h200, 12'h201, 12'h302, 12'h500};
   endfunction

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      addr = a; re = 1'b1;
      #1 d = rdata;
      tick();
      re = 1'b0;
   endtask

   task automatic peek(input logic [31:0] a, output logic [31:0] d);
      addr = a; re = 1'b1;
      #1 d = rdata;
      re = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      clrn = 1'b0;
      #2;
      vectors++;
      if (led !== 16'h0 || hex !== 32'h0 || key_irq !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_outputs led=%h hex=%h irq=%b, required 0/0/0", led, hex, key_irq);
      end
      tick(); #2 clrn = 1'b1;
      tick();
      peek(A_KSTAT, d);
      vectors++;
      if (d !== 32'h1) begin
         miscompares++; $display("FAIL reset_kstat got %h, required 00000001", d);
      end
      peek(A_ERR, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL reset_err got %h, required 0", d);
      end
      peek(A_CUS, d);
      vectors++;
      if (d > 32'd2) begin
         miscompares++; $display("FAIL reset_clk_us got %0d, required <=2", d);
      end
      q.delete(); ovf_m = 1'b0;
   endtask

   task automatic test_regs();
      logic [31:0] d, v;
      do_write(A_LED, 32'h0000A5A5);
      vectors++;
      if (led !== 16'hA5A5) begin
         miscompares++; $display("FAIL led_write got %h, required a5a5", led);
      end
      do_read(A_LED, d);
      vectors++;
      if (d !== 32'h0000A5A5) begin
         miscompares++; $display("FAIL led_read got %h, required 0000a5a5", d);
      end
      for (int i = 0; i < 6; i++) begin
         v = $urandom;
         do_write(A_LED, v);
         do_read(A_LED, d);
         vectors++;
         if (led !== v[15:0] || d !== {16'h0, v[15:0]}) begin
            miscompares++; $display("FAIL led_rand led=%h rd=%h, required %h", led, d, v[15:0]);
         end
         v = $urandom;
         do_write(A_HEX, v);
         do_read(A_HEX, d);
         vectors++;
         if (hex !== v || d !== v) begin
            miscompares++; $display("FAIL hex_rand hex=%h rd=%h, required %h", hex, d, v);
         end
         sw = 16'($urandom); dmem_rdata = $urandom;
         peek(A_SW, d);
         vectors++;
         if (d !== {16'h0, sw}) begin
            miscompares++; $display("FAIL sw_read got %h, required %h", d, {16'h0, sw});
         end
         peek(A_DATA, d);
         vectors++;
         if (d !== dmem_rdata) begin
            miscompares++; $display("FAIL data_read got %h, required %h", d, dmem_rdata);
         end
      end
      addr = A_DATA; we = 1'b1; #1;
      vectors++;
      if (dmem_we !== 1'b1) begin
         miscompares++; $display("FAIL dmem_we_data got %b, required 1", dmem_we);
      end
      addr = A_HEX; #1;
      vectors++;
      if (dmem_we !== 1'b0) begin
         miscompares++; $display("FAIL dmem_we_hex got %b, required 0", dmem_we);
      end
      we = 1'b0;
   endtask

   task automatic push_code(input logic [7:0] c);
      key_code = c; key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      if (q.size() < 8) q.push_back(c); else ovf_m = 1'b1;
   endtask

   task automatic test_key_fifo();
      logic [31:0] d;
      logic [7:0]  e;
      for (int i = 1; i <= 9; i++) push_code(8'(i));
      peek(A_KSTAT, d);
      vectors++;
      if (d !== stat_exp() || d[31] !== 1'b1 || d[11:8] !== 4'd8) begin
         miscompares++; $display("FAIL kstat_overflow got %h, required %h", d, stat_exp());
      end
      for (int i = 0; i < 8; i++) begin
         vectors++;
         if (key_irq !== 1'b1) begin
            miscompares++; $display("FAIL irq_nonempty got %b, required 1", key_irq);
         end
         e = q.pop_front();
         do_read(A_KCODE, d);
         vectors++;
         if (d !== {24'h0, e}) begin
            miscompares++; $display("FAIL pop_%0d got %h, required %h", i, d, e);
         end
      end
      do_read(A_KCODE, d);
      vectors++;
      if (d !== 32'h0 || key_irq !== 1'b0) begin
         miscompares++; $display("FAIL pop_empty rd=%h irq=%b, required 0/0", d, key_irq);
      end
      do_write(A_KSTAT, $urandom);
      ovf_m = 1'b0;
      peek(A_KSTAT, d);
      vectors++;
      if (d !== stat_exp()) begin
         miscompares++; $display("FAIL kstat_clear got %h, required %h", d, stat_exp());
      end
   endtask

   task automatic test_full_push_pop();
      logic [31:0] d;
      logic [7:0]  e;
      for (int i = 0; i < 8; i++) push_code(8'($urandom));
      addr = A_KCODE; re = 1'b1; key_code = 8'h1C; key_valid = 1'b1;
      #1 d = rdata;
      tick();
      re = 1'b0; key_valid = 1'b0;
      e = q.pop_front(); q.push_back(8'h1C);
      vectors++;
      if (d !== {24'h0, e}) begin
         miscompares++; $display("FAIL full_pp_rdata got %h, required %h", d, e);
      end
      peek(A_KSTAT, d);
      vectors++;
      if (d !== stat_exp() || d[11:8] !== 4'd8) begin
         miscompares++; $display("FAIL full_pp_stat got %h, required %h", d, stat_exp());
      end
      for (int i = 0; i < 8; i++) begin
         e = q.pop_front();
         do_read(A_KCODE, d);
         vectors++;
         if (d !== {24'h0, e}) begin
            miscompares++; $display("FAIL full_pp_drain_%0d got %h, required %h", i, d, e);
         end
      end
   endtask

   task automatic test_empty_push_pop();
      logic [31:0] d;
      logic [7:0]  c;
      c = 8'($urandom_range(1, 255));
      addr = A_KCODE; re = 1'b1; key_code = c; key_valid = 1'b1;
      #1 d = rdata;
      tick();
      re = 1'b0; key_valid = 1'b0;
      q.push_back(c);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL empty_pp_rdata got %h, required 0", d);
      end
      peek(A_KSTAT, d);
      vectors++;
      if (d !== stat_exp() || key_irq !== 1'b1) begin
         miscompares++; $display("FAIL empty_pp_stat got %h irq=%b, required %h irq=1", d, key_irq, stat_exp());
      end
      peek(A_ERR, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL empty_pop_no_err got %h, required 0", d);
      end
      do_read(A_KCODE, d);
      void'(q.pop_front());
      vectors++;
      if (d !== {24'h0, c}) begin
         miscompares++; $display("FAIL empty_pp_stored got %h, required %h", d, c);
      end
   endtask

   task automatic test_random_fifo();
      logic [31:0] d, e;
      bit pu, po;
      for (int i = 0; i < 300; i++) begin
         pu = ($urandom_range(0, 99) < 55);
         po = ($urandom_range(0, 99) < 45);
         addr = A_KCODE; re = po; key_valid = pu; key_code = 8'($urandom);
         #1 d = rdata;
         e = (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
         vectors++;
         if (d !== e) begin
            miscompares++; $display("FAIL rand_fifo_rd cycle %0d got %h, required %h", i, d, e);
         end
         if (po && q.size() != 0) begin
            void'(q.pop_front());
            q.push_back(key_code);
            if (!pu) void'(q.pop_back());
         end else if (pu) begin
            if (q.size() < 8) q.push_back(key_code); else ovf_m = 1'b1;
         end
         tick();
         vectors++;
         if (key_irq !== (q.size() != 0)) begin
            miscompares++; $display("FAIL rand_fifo_irq cycle %0d got %b, required %b", i, key_irq, q.size() != 0);
         end
      end
      re = 1'b0; key_valid = 1'b0;
      peek(A_KSTAT, d);
      vectors++;
      if (d !== stat_exp()) begin
         miscompares++; $display("FAIL rand_fifo_stat got %h, required %h", d, stat_exp());
      end
   endtask

   task automatic check_clocks(input int n, input string tag);
      logic [31:0] us, ms, s;
      peek(A_CUS, us); peek(A_CMS, ms); peek(A_CS, s);
      vectors++;
      if (us !== 32'(n / 2) || ms !== 32'(n / 2000) || s !== 32'(n / 2000000)) begin
         miscompares++;
         $display("FAIL %s us=%0d ms=%0d s=%0d, required %0d/%0d/%0d", tag, us, ms, s, n / 2, n / 2000, n / 2000000);
      end
   endtask

   task automatic test_timebase();
      int n;
      do_write(A_CUS, $urandom);
      check_clocks(0, "clk_clear");
      repeat (2000) tick();
      check_clocks(2000, "clk_2000");
      do_write(A_CUS, 32'h0);
      check_clocks(0, "clk_write_clear");
      for (int k = 0; k < 2; k++) begin
         n = $urandom_range(1, 6000);
         do_write(A_CUS, $urandom);
         repeat (n) tick();
         check_clocks(n, "clk_rand");
      end
   endtask

   task automatic test_err();
      logic [31:0] d, exp_e;
      logic [11:0] r;
      do_write(A_ERR, 32'h0);
      do_write(A_SW, $urandom);
      do_read(32'h7FF0_0000, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL unmapped_read got %h, required 0", d);
      end
      peek(A_ERR, d);
      vectors++;
      if (d !== 32'hC000_0400) begin
         miscompares++; $display("FAIL err_first got %h, required c0000400", d);
      end
      do_write(A_ERR, $urandom);
      peek(A_ERR, d);
      vectors++;
      if (d !== 32'h0) begin
         miscompares++; $display("FAIL err_clear got %h, required 0", d);
      end
      for (int i = 0; i < 12; i++) begin
         r = 12'($urandom);
         if (i % 3 == 0) r = 12'h300 + 12'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) begin
            addr = {r, 20'($urandom)}; wdata = $urandom; we = 1'b1;
            exp_e = is_writable(r) ? 32'h0 : {1'b1, 1'b1, 18'h0, r};
         end else begin
            addr = {r, 20'($urandom)}; re = 1'b1;
            exp_e = is_mapped(r) ? 32'h0 : {1'b1, 1'b0, 18'h0, r};
         end
         tick();
         we = 1'b0; re = 1'b0;
         if (r == 12'h500) exp_e = 32'h0;
         peek(A_ERR, d);
         vectors++;
         if (d !== exp_e) begin
            miscompares++; $display("FAIL err_rand region %h got %h, required %h", r, d, exp_e);
         end
         do_write(A_ERR, 32'h0);
         if (r == 12'h101) begin
            ovf_m = 1'b0;
         end
      end
   endtask

   task automatic test_reset_midop();
      logic [31:0] d;
      do_write(A_LED, 32'h0000FFFF);
      for (int i = 0; i < 3; i++) push_code(8'($urandom));
      vectors++;
      if (led !== 16'hFFFF || key_irq !== 1'b1) begin
         miscompares++; $display("FAIL pre_reset led=%h irq=%b, required ffff/1", led, key_irq);
      end
      #2 clrn = 1'b0;
      #1;
      vectors++;
      if (led !== 16'h0 || key_irq !== 1'b0 || hex !== 32'h0) begin
         miscompares++; $display("FAIL async_reset led=%h irq=%b hex=%h, required 0/0/0", led, key_irq, hex);
      end
      peek(A_KSTAT, d);
      vectors++;
      if (d !== 32'h1) begin
         miscompares++; $display("FAIL async_reset_kstat got %h, required 00000001", d);
      end
      tick(); #2 clrn = 1'b1;
      tick();
      q.delete(); ovf_m = 1'b0;
      peek(A_KCODE, d);
      vectors++;
      if (d !== 32'h0 || key_irq !== 1'b0) begin
         miscompares++; $display("FAIL post_reset rd=%h irq=%b, required 0/0", d, key_irq);
      end
   endtask

   initial begin
      test_reset();
      test_regs();
      test_key_fifo();
      test_full_push_pop();
      test_empty_push_pop();
      test_random_fifo();
      test_timebase();
      test_err();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
